// File: rtl/fp_div_sched_if.sv
// Bundle of requester, divider and response signals shared by fp_div_sched and its environment.
interface fp_div_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           div_a;
  logic [31:0]           div_b;
  logic [31:0]           div_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, div_result, rsp_ready,
    input  req_ready, div_a, div_b, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, div_result, rsp_ready,
    output req_ready, div_a, div_b, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one external combinational FP divider among NUM_REQ requesters,
// holding registered operands for a LATENCY-cycle multicycle window before sampling the quotient.
module fp_div_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_div_sched_if.slave   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     pend_id_q, pend_id_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   div_a_q, div_a_d;
  logic [DATA_W-1:0]   div_b_q, div_b_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   op_a [NUM_REQ];
  logic [DATA_W-1:0]   op_b [NUM_REQ];
  logic [NUM_REQ-1:0]  req_ready_c;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_vld;
  int unsigned         cand;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_a[k] = bus.req_a[DATA_W*k +: DATA_W];
      op_b[k] = bus.req_b[DATA_W*k +: DATA_W];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && bus.req_valid[ID_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (state_q == S_IDLE && grant_vld) req_ready_c[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    pend_id_d    = pend_id_q;
    rsp_id_d     = rsp_id_q;
    cnt_d        = cnt_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          div_a_d   = op_a[grant_idx];
          div_b_d   = op_b[grant_idx];
          pend_id_d = grant_idx;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          rsp_result_d = bus.div_result;
          rsp_id_d     = pend_id_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // Return to IDLE only; the next grant is evaluated in the following cycle.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      pend_id_q    <= '0;
      rsp_id_q     <= '0;
      cnt_q        <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      pend_id_q    <= pend_id_d;
      rsp_id_q     <= rsp_id_d;
      cnt_q        <= cnt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched: LATENCY=2 main instance plus LATENCY=1 and LATENCY=15 builds.
module tb_fp_div_sched;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fp_div_sched_if #(.NUM_REQ(4), .ID_W(2)) bus2 ();
  fp_div_sched_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();
  fp_div_sched_if #(.NUM_REQ(4), .ID_W(2)) bus15 ();

  fp_div_sched #(.NUM_REQ(4), .LATENCY(2))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus2));
  fp_div_sched #(.NUM_REQ(4), .LATENCY(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fp_div_sched #(.NUM_REQ(4), .LATENCY(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

  // Divider stand-in: hand-computed IEEE-754 single quotients for the operand pairs used here.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: fdiv = 32'h40400000;
      64'h3F800000_00000000: fdiv = 32'h7F800000;
      64'h41000000_40000000: fdiv = 32'h40800000;
      64'h3F800000_40000000: fdiv = 32'h3F000000;
      64'h41200000_40800000: fdiv = 32'h40200000;
      64'hC0800000_40000000: fdiv = 32'hC0000000;
      default:               fdiv = 32'hDEADBEEF;
    endcase
  endfunction

  assign bus2.div_result  = fdiv(bus2.div_a, bus2.div_b);
  assign bus1.div_result  = fdiv(bus1.div_a, bus1.div_b);
  assign bus15.div_result = fdiv(bus15.div_a, bus15.div_b);

  logic        l_valid [2];
  logic [31:0] o_div_a [2];
  logic [31:0] o_div_b [2];
  logic [31:0] o_res   [2];
  logic        o_vld   [2];
  logic        o_busy  [2];

  assign bus1.req_valid  = {3'b000, l_valid[0]};
  assign bus15.req_valid = {3'b000, l_valid[1]};
  assign bus1.req_a      = {96'd0, 32'h41000000};
  assign bus1.req_b      = {96'd0, 32'h40000000};
  assign bus15.req_a     = {96'd0, 32'h41000000};
  assign bus15.req_b     = {96'd0, 32'h40000000};
  assign bus1.rsp_ready  = 1'b1;
  assign bus15.rsp_ready = 1'b1;
  assign o_div_a[0] = bus1.div_a;      assign o_div_a[1] = bus15.div_a;
  assign o_div_b[0] = bus1.div_b;      assign o_div_b[1] = bus15.div_b;
  assign o_res[0]   = bus1.rsp_result; assign o_res[1]   = bus15.rsp_result;
  assign o_vld[0]   = bus1.rsp_valid;  assign o_vld[1]   = bus15.rsp_valid;
  assign o_busy[0]  = bus1.busy;       assign o_busy[1]  = bus15.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus2.rsp_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.req_valid = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.rsp_ready = 1'b0;
    l_valid[0] = 1'b0; l_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus2.busy); end
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", bus2.rsp_valid); end
    checks++; if (bus2.req_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready: got %b expected 0000", bus2.req_ready); end
    checks++; if (bus2.div_a !== 32'h0) begin errors++; $display("FAIL reset div_a: got %h expected 0", bus2.div_a); end
    checks++; if (bus2.div_b !== 32'h0) begin errors++; $display("FAIL reset div_b: got %h expected 0", bus2.div_b); end
    checks++; if (bus2.rsp_id !== 2'd0) begin errors++; $display("FAIL reset rsp_id: got %0d expected 0", bus2.rsp_id); end
    checks++; if (bus2.rsp_result !== 32'h0) begin errors++; $display("FAIL reset rsp_result: got %h expected 0", bus2.rsp_result); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic [31:0] rq [4];
    int n;
    ra = '{32'h41000000, 32'h3F800000, 32'h41200000, 32'hC0800000};
    rb = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h40000000};
    rq = '{32'h40800000, 32'h3F000000, 32'h40200000, 32'hC0000000};
    for (int k = 0; k < 4; k++) begin
      bus2.req_a[32*k +: 32] = ra[k];
      bus2.req_b[32*k +: 32] = rb[k];
    end
    bus2.rsp_ready = 1'b1;
    bus2.req_valid = 4'hF;
    n = 0;
    #1;
    for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
      checks++;
      if ($countones(bus2.req_ready) > 1) begin errors++; $display("FAIL rr onehot: got %b expected at most one bit", bus2.req_ready); end
      if (bus2.rsp_valid === 1'b1) begin
        checks++;
        if (bus2.rsp_id !== 2'(n % 4)) begin errors++; $display("FAIL rr rsp_id op%0d: got %0d expected %0d", n, bus2.rsp_id, n % 4); end
        checks++;
        if (bus2.rsp_result !== rq[n % 4]) begin errors++; $display("FAIL rr rsp_result op%0d: got %h expected %h", n, bus2.rsp_result, rq[n % 4]); end
        n++;
      end
      tick();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL rr timeout: got %0d responses expected 8", n); end
    bus2.req_valid = '0;
    tick();
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rr idle busy: got %b expected 0", bus2.busy); end
  endtask

  task automatic test_single_op();
    bus2.req_a[63:32] = 32'h40C00000;
    bus2.req_b[63:32] = 32'h40000000;
    bus2.req_valid = 4'b0010;
    #1;
    checks++; if (bus2.req_ready !== 4'b0010) begin errors++; $display("FAIL single req_ready: got %b expected 0010", bus2.req_ready); end
    tick();
    bus2.req_valid = '0;
    #1;
    checks++; if (bus2.busy !== 1'b1) begin errors++; $display("FAIL single busy: got %b expected 1", bus2.busy); end
    checks++; if (bus2.div_a !== 32'h40C00000) begin errors++; $display("FAIL single div_a: got %h expected 40c00000", bus2.div_a); end
    checks++; if (bus2.div_b !== 32'h40000000) begin errors++; $display("FAIL single div_b: got %h expected 40000000", bus2.div_b); end
    tick();
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL single early rsp_valid: got %b expected 0", bus2.rsp_valid); end
    tick();
    checks++; if (bus2.rsp_valid !== 1'b1) begin errors++; $display("FAIL single rsp_valid: got %b expected 1", bus2.rsp_valid); end
    checks++; if (bus2.rsp_id !== 2'd1) begin errors++; $display("FAIL single rsp_id: got %0d expected 1", bus2.rsp_id); end
    checks++; if (bus2.rsp_result !== 32'h40400000) begin errors++; $display("FAIL single rsp_result: got %h expected 40400000", bus2.rsp_result); end
    tick();
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL single rsp_valid drop: got %b expected 0", bus2.rsp_valid); end
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL single busy drop: got %b expected 0", bus2.busy); end
  endtask

  task automatic test_special();
    bit ok;
    bus2.req_a[95:64] = 32'h3F800000;
    bus2.req_b[95:64] = 32'h00000000;
    bus2.req_valid = 4'b0100;
    #1;
    checks++; if (bus2.req_ready !== 4'b0100) begin errors++; $display("FAIL special req_ready: got %b expected 0100", bus2.req_ready); end
    tick();
    bus2.req_valid = '0;
    wait_rsp2(ok);
    checks++; if (!ok) begin errors++; $display("FAIL special timeout: got no rsp_valid expected 1"); end
    checks++; if (bus2.rsp_result !== 32'h7F800000) begin errors++; $display("FAIL special rsp_result: got %h expected 7f800000", bus2.rsp_result); end
    checks++; if (bus2.rsp_id !== 2'd2) begin errors++; $display("FAIL special rsp_id: got %0d expected 2", bus2.rsp_id); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    bus2.rsp_ready = 1'b0;
    bus2.req_a[127:96] = 32'h41200000;
    bus2.req_b[127:96] = 32'h40800000;
    bus2.req_a[31:0]   = 32'h41000000;
    bus2.req_b[31:0]   = 32'h40000000;
    bus2.req_valid = 4'b1000;
    #1;
    checks++; if (bus2.req_ready !== 4'b1000) begin errors++; $display("FAIL bp req_ready: got %b expected 1000", bus2.req_ready); end
    tick();
    bus2.req_valid = 4'b0001;
    wait_rsp2(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp timeout: got no rsp_valid expected 1"); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus2.rsp_valid !== 1'b1 || bus2.rsp_id !== 2'd3 || bus2.rsp_result !== 32'h40200000 || bus2.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp hold c%0d: got vld=%b id=%0d res=%h rdy=%b expected vld=1 id=3 res=40200000 rdy=0000",
                 c, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_result, bus2.req_ready);
      end
      tick();
    end
    bus2.rsp_ready = 1'b1;
    #1;
    checks++; if (bus2.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp pre-handshake rsp_valid: got %b expected 1", bus2.rsp_valid); end
    tick();
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp post-handshake rsp_valid: got %b expected 0", bus2.rsp_valid); end
    checks++; if (bus2.req_ready !== 4'b0001) begin errors++; $display("FAIL bp next grant: got %b expected 0001", bus2.req_ready); end
    tick();
    bus2.req_valid = '0;
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp duplicate rsp_valid: got %b expected 0", bus2.rsp_valid); end
    wait_rsp2(ok);
    checks++; if (!ok || bus2.rsp_id !== 2'd0 || bus2.rsp_result !== 32'h40800000) begin
      errors++; $display("FAIL bp follow-on: got ok=%b id=%0d res=%h expected ok=1 id=0 res=40800000", ok, bus2.rsp_id, bus2.rsp_result);
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    bus2.req_a[95:64] = 32'h41200000;
    bus2.req_b[95:64] = 32'h40800000;
    bus2.req_valid = 4'b0100;
    #1;
    checks++; if (bus2.req_ready !== 4'b0100) begin errors++; $display("FAIL rst req_ready: got %b expected 0100", bus2.req_ready); end
    tick();
    bus2.req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rst busy: got %b expected 0", bus2.busy); end
    checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst rsp_valid: got %b expected 0", bus2.rsp_valid); end
    checks++; if (bus2.div_a !== 32'h0 || bus2.div_b !== 32'h0) begin errors++; $display("FAIL rst div: got %h/%h expected 0/0", bus2.div_a, bus2.div_b); end
    checks++; if (bus2.rsp_result !== 32'h0) begin errors++; $display("FAIL rst rsp_result: got %h expected 0", bus2.rsp_result); end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus2.rsp_valid !== 1'b0 || bus2.busy !== 1'b0) begin
        errors++; $display("FAIL rst ghost c%0d: got vld=%b busy=%b expected 0/0", c, bus2.rsp_valid, bus2.busy);
      end
    end
    bus2.req_valid = 4'hF;
    #1;
    checks++; if (bus2.req_ready !== 4'b0001) begin errors++; $display("FAIL rst rr restart: got %b expected 0001", bus2.req_ready); end
    tick();
    bus2.req_valid = '0;
    wait_rsp2(ok);
    checks++; if (!ok || bus2.rsp_id !== 2'd0) begin errors++; $display("FAIL rst post op: got ok=%b id=%0d expected ok=1 id=0", ok, bus2.rsp_id); end
    tick();
  endtask

  task automatic test_latency(input int sel, input int lat);
    logic [31:0] a0, b0;
    bit done;
    l_valid[sel] = 1'b1;
    tick();
    l_valid[sel] = 1'b0;
    a0 = o_div_a[sel];
    b0 = o_div_b[sel];
    checks++; if (a0 !== 32'h41000000 || b0 !== 32'h40000000) begin errors++; $display("FAIL lat%0d operands: got %h/%h expected 41000000/40000000", lat, a0, b0); end
    done = 1'b0;
    for (int e = 1; e <= 40 && !done; e++) begin
      tick();
      if (o_vld[sel] === 1'b1) begin
        done = 1'b1;
        checks++; if (e != lat) begin errors++; $display("FAIL lat%0d latency: got %0d expected %0d", lat, e, lat); end
        checks++; if (o_res[sel] !== 32'h40800000) begin errors++; $display("FAIL lat%0d result: got %h expected 40800000", lat, o_res[sel]); end
      end else begin
        checks++;
        if (o_div_a[sel] !== a0 || o_div_b[sel] !== b0) begin
          errors++; $display("FAIL lat%0d hold e%0d: got %h/%h expected %h/%h", lat, e, o_div_a[sel], o_div_b[sel], a0, b0);
        end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL lat%0d timeout: got no rsp_valid expected 1", lat); end
    tick();
    checks++; if (o_vld[sel] !== 1'b0 || o_busy[sel] !== 1'b0) begin errors++; $display("FAIL lat%0d idle: got vld=%b busy=%b expected 0/0", lat, o_vld[sel], o_busy[sel]); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_op();
    test_special();
    test_backpressure();
    test_reset_mid_exec();
    test_latency(0, 1);
    test_latency(1, 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
